// File: rtl/clock_disp_pkg.sv
// Shared constants and helpers for the clock display scan path.
package clock_disp_pkg;

  localparam int unsigned BCD_W            = 4;
  localparam logic [3:0]  BLANK_CODE       = 4'hF;
  localparam int unsigned MAX_DIGITS       = 8;
  localparam int unsigned DEF_NUM_DIGITS   = 6;
  localparam int unsigned DEF_SCAN_DIV     = 50000;
  localparam int unsigned DEF_GUARD_CYCLES = 500;

  // Marks the run of zero digits from the top of an n-digit field; digit 0 is never marked.
  function automatic logic [MAX_DIGITS-1:0] lead_zero_mask(
    input logic [BCD_W*MAX_DIGITS-1:0] digits,
    input int                          n
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  run;
    mask = '0;
    run  = 1'b1;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      if (i < n) begin
        if (run && (digits[BCD_W*i +: BCD_W] == 4'h0)) begin
          mask[i] = 1'b1;
        end else begin
          run = 1'b0;
        end
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/display_scan_mux_scan_timer.sv
// Slot divider and digit index counters for the display scan, plus frame_start.
module scan_timer
  import clock_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int unsigned SCAN_DIV   = DEF_SCAN_DIV
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [$clog2(NUM_DIGITS)-1:0] idx_q,
  output logic [$clog2(SCAN_DIV)-1:0]   div_cnt_d_c,
  output logic [$clog2(NUM_DIGITS)-1:0] idx_d_c,
  output logic                          snap_take_c,
  output logic                          frame_start_q
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0] div_cnt_q;
  logic             div_end;
  logic             idx_end;

  always_comb begin
    div_end     = (div_cnt_q == CNT_W'(SCAN_DIV - 1));
    idx_end     = (idx_q == IDX_W'(NUM_DIGITS - 1));
    div_cnt_d_c = div_end ? '0 : div_cnt_q + CNT_W'(1);
    idx_d_c     = idx_q;
    if (div_end) begin
      idx_d_c = idx_end ? '0 : idx_q + IDX_W'(1);
    end
    snap_take_c = div_end && idx_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d_c;
      idx_q         <= idx_d_c;
      frame_start_q <= (div_cnt_q == '0) && (idx_q == '0);
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scan ahead of the 7-segment decoder, with guard interval and frame snapshot.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits at snapshot time.
module display_scan_mux
  import clock_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV,
  parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic                          disp_en,
  output logic [BCD_W-1:0]              digit_q,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic                          dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned DIG_W = BCD_W * NUM_DIGITS;

  logic [CNT_W-1:0]      div_cnt_d;
  logic [IDX_W-1:0]      idx_d;
  logic [IDX_W-1:0]      idx_q;
  logic                  snap_take;
  logic                  frame_start_q;
  logic                  in_guard;

  logic [DIG_W-1:0]      snap_q, snap_d;
  logic [NUM_DIGITS-1:0] dp_snap_q, dp_snap_d;
  logic [NUM_DIGITS-1:0] blank_snap_q, blank_snap_d;
  logic [NUM_DIGITS-1:0] lz_mask;

  logic [BCD_W-1:0]      cur_code;
  logic                  dark;
  logic [BCD_W-1:0]      digit_q_q, digit_q_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  dp_n_q, dp_n_d;

  scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan_timer (
    .clk           (clk),
    .rst           (rst),
    .idx_q         (idx_q),
    .div_cnt_d_c   (div_cnt_d),
    .idx_d_c       (idx_d),
    .snap_take_c   (snap_take),
    .frame_start_q (frame_start_q)
  );

  if (GUARD_CYCLES == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    assign in_guard = (div_cnt_d < CNT_W'(GUARD_CYCLES));
  end

`ifdef LEADING_ZERO_BLANK_EN
  localparam int unsigned PAD_W = BCD_W * MAX_DIGITS;
  assign lz_mask = NUM_DIGITS'(lead_zero_mask(PAD_W'(digits_in), int'(NUM_DIGITS)));
`else
  assign lz_mask = '0;
`endif

  // Frame snapshot, refreshed on the edge that wraps into slot 0.
  always_comb begin
    snap_d       = snap_q;
    dp_snap_d    = dp_snap_q;
    blank_snap_d = blank_snap_q;
    if (snap_take) begin
      snap_d       = digits_in;
      dp_snap_d    = dp_mask;
      blank_snap_d = blank_mask | lz_mask;
    end
  end

  // Outputs follow the post-edge slot; a captured BLANK_CODE also keeps the anode dark.
  always_comb begin
    cur_code  = snap_d[BCD_W*idx_d +: BCD_W];
    dark      = blank_snap_d[idx_d] || (cur_code == BLANK_CODE);
    digit_q_d = blank_snap_d[idx_d] ? BLANK_CODE : cur_code;
    an_n_d    = '1;
    dp_n_d    = 1'b1;
    if (!in_guard && disp_en && !dark) begin
      an_n_d = ~(NUM_DIGITS'(1) << idx_d);
      dp_n_d = ~dp_snap_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q       <= {NUM_DIGITS{BLANK_CODE}};
      dp_snap_q    <= '0;
      blank_snap_q <= '0;
      digit_q_q    <= BLANK_CODE;
      an_n_q       <= '1;
      dp_n_q       <= 1'b1;
    end else begin
      snap_q       <= snap_d;
      dp_snap_q    <= dp_snap_d;
      blank_snap_q <= blank_snap_d;
      digit_q_q    <= digit_q_d;
      an_n_q       <= an_n_d;
      dp_n_q       <= dp_n_d;
    end
  end

  assign digit_q     = digit_q_q;
  assign an_n        = an_n_q;
  assign dp_n        = dp_n_q;
  assign digit_idx   = idx_q;
  assign frame_start = frame_start_q;

endmodule
